seg7_display_monitor: RTL



---
 rtl/seg7_display_monitor_if.sv | 29 ++
 rtl/seg7_display_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_monitor_if.sv
// +--------------------------------------------------------------------------+
// | seg7_display_monitor_if : segment bus / digit select plus decoded result |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface seg7_display_monitor_if #(
  parameter int DW = 8
);
  logic [DW-1:0] seg_in;
  logic          c_in;
  logic [7:0]    value;
  logic          value_valid;
  logic          code_err;
  logic          stale;
  logic [1:0]    dp;

  modport master (
    output seg_in, c_in,
    input  value, value_valid, code_err, stale, dp
  );

  modport slave (
    input  seg_in, c_in,
    output value, value_valid, code_err, stale, dp
  );
endinterface

`default_nettype wire

// File: rtl/seg7_display_monitor.sv
// +--------------------------------------------------------------------------+
// | seg7_display_monitor : rebuilds the byte shown on a 2-digit muxed 7-seg   |
// | Optional macro SEG7_MONITOR_INPUT_SYNC_EN adds a 2-flop input synchronizer|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_display_monitor #(
  parameter int DW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  seg7_display_monitor_if.slave         mon
);

  localparam int             C_TW      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]     C_SETTLE  = 8'(SETTLE);
  localparam logic [C_TW-1:0] C_TIMEOUT = C_TW'(TIMEOUT);
  localparam logic [C_TW-1:0] C_TO_ONE  = C_TW'(1);

  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic [DW:0]     w_in;
  logic [DW:0]     r_samp;
  logic [7:0]      r_cnt;
  logic            r_phase_done;
  logic [C_TW-1:0] r_to_cnt;
  logic [3:0]      r_hi, r_lo;
  logic            r_hi_dp, r_lo_dp;
  logic [7:0]      r_value;
  logic [1:0]      r_dp;
  logic            r_valid, r_err;

  logic            w_edge, w_rise, w_settled;
  logic [3:0]      w_nib;
  logic            w_legal, w_blank;
  logic            w_cap_hi, w_cap_lo, w_err, w_consume;

`ifdef SEG7_MONITOR_INPUT_SYNC_EN
  logic [DW:0] r_sync1, r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {mon.c_in, mon.seg_in};
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = {mon.c_in, mon.seg_in};
`endif

  assign w_edge    = w_in[DW] ^ r_samp[DW];
  assign w_rise    = w_in[DW] & ~r_samp[DW];
  // r_samp is the settled pattern once the counter saturates; a fresh phase is required per capture
  assign w_settled = (r_cnt == C_SETTLE) && !r_phase_done;

  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (r_samp[6:0])
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      7'h00: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cap_hi  = 1'b0;
    w_cap_lo  = 1'b0;
    w_err     = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      ST_WAIT_HI: begin
        if (w_settled && r_samp[DW]) begin
          w_consume = 1'b1;
          if (w_legal) begin
            w_cap_hi = 1'b1;
            w_next   = ST_WAIT_LO;
          end else if (!w_blank) begin
            w_err = 1'b1;
          end
        end
      end
      ST_WAIT_LO: begin
        // a new high phase before the low capture restarts the frame
        if (w_rise) begin
          w_next = ST_WAIT_HI;
        end else if (w_settled && !r_samp[DW]) begin
          w_consume = 1'b1;
          if (w_legal) begin
            w_cap_lo = 1'b1;
            w_next   = ST_EMIT;
          end else begin
            w_err  = !w_blank;
            w_next = ST_WAIT_HI;
          end
        end
      end
      ST_EMIT:  w_next = ST_WAIT_HI;
      default:  w_next = ST_WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_samp       <= '0;
      r_cnt        <= '0;
      r_phase_done <= 1'b0;
      r_to_cnt     <= '0;
    end else begin
      r_samp <= w_in;
      if (w_in != r_samp)        r_cnt <= '0;
      else if (r_cnt != C_SETTLE) r_cnt <= r_cnt + 8'd1;
      if (w_edge)         r_phase_done <= 1'b0;
      else if (w_consume) r_phase_done <= 1'b1;
      if (w_edge)                    r_to_cnt <= '0;
      else if (r_to_cnt != C_TIMEOUT) r_to_cnt <= r_to_cnt + C_TO_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= 4'h0;
      r_lo    <= 4'h0;
      r_hi_dp <= 1'b0;
      r_lo_dp <= 1'b0;
      r_value <= 8'h00;
      r_dp    <= 2'b00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_EMIT);
      r_err   <= w_err;
      if (w_cap_hi) begin
        r_hi    <= w_nib;
        r_hi_dp <= r_samp[7];
      end
      if (w_cap_lo) begin
        r_lo    <= w_nib;
        r_lo_dp <= r_samp[7];
      end
      if (r_state == ST_EMIT) begin
        r_value <= {r_hi, r_lo};
        r_dp    <= {r_hi_dp, r_lo_dp};
      end
    end
  end

  assign mon.value       = r_value;
  assign mon.value_valid = r_valid;
  assign mon.code_err    = r_err;
  assign mon.stale       = (r_to_cnt == C_TIMEOUT);
  assign mon.dp          = r_dp;

endmodule

`default_nettype wire
